// File: rtl/jtpopeye_obj_scan_pkg.sv
// Shared object-buffer definitions: entry layout, object height and scan FSM states.
package jtpopeye_obj_scan_pkg;

    localparam int unsigned OBJ_DW     = 29;
    localparam int unsigned OBJ_H      = 16;
    localparam int unsigned OBJ_YPIX_W = $clog2(OBJ_H);

    // Bit layout of one object buffer entry, MSB first
    typedef struct packed {
        logic       bank;
        logic       vflip;
        logic [2:0] pal;
        logic       hflip;
        logic [6:0] code;
        logic [7:0] y;
        logic [7:0] x;
    } obj_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CHECK,
        ST_WAIT,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/jtpopeye_obj_match.sv
// Combinational scanline hit test for one object; ypix has vflip applied.
module jtpopeye_obj_match
    import jtpopeye_obj_scan_pkg::*;
(
    input  logic [7:0]            vrender,
    input  logic [7:0]            y,
    input  logic                  vflip,
    output logic                  hit,
    output logic [OBJ_YPIX_W-1:0] ypix
);

    logic [7:0] w_ydiff;

    // Wraps modulo 256 so objects straddling line 0 still match
    assign w_ydiff = vrender - y;
    assign hit     = (w_ydiff < 8'(OBJ_H));
    assign ypix    = w_ydiff[OBJ_YPIX_W-1:0] ^ {OBJ_YPIX_W{vflip}};

endmodule

// File: rtl/jtpopeye_obj_scan.sv
// Per-line object scanner: walks the object buffer during HB and issues draw commands.
module jtpopeye_obj_scan
    import jtpopeye_obj_scan_pkg::*;
#(
    parameter int unsigned OBJMAX = 64,
    parameter int unsigned HITMAX = 8
)(
    input  logic                  rst_n,
    input  logic                  clk,
    input  logic                  cen,
    input  logic                  VB,
    input  logic                  HB,
    input  logic [7:0]            vrender,
    output logic [7:0]            obj_addr,
    input  logic [OBJ_DW-1:0]     obj_data,
    output logic                  dr_start,
    input  logic                  dr_busy,
    output logic [7:0]            dr_x,
    output logic [6:0]            dr_code,
    output logic [OBJ_YPIX_W-1:0] dr_ypix,
    output logic                  dr_hflip,
    output logic [2:0]            dr_pal,
    output logic                  dr_bank,
    output logic                  scan_done
);

    localparam int unsigned    HCW       = $clog2(HITMAX + 1);
    localparam logic [7:0]     LAST_ADDR = 8'(OBJMAX - 1);
    localparam logic [HCW-1:0] HIT_LIMIT = HCW'(HITMAX);

    scan_state_t           r_state;
    obj_entry_t            r_entry;
    logic                  r_hb_last;
    logic [HCW-1:0]        r_hits;

    logic                  w_hb_rise;
    logic                  w_match;
    logic                  w_hit;
    logic                  w_last_addr;
    logic [HCW-1:0]        w_hits_inc;
    logic [OBJ_YPIX_W-1:0] w_ypix;

    jtpopeye_obj_match u_match (
        .vrender (vrender),
        .y       (r_entry.y),
        .vflip   (r_entry.vflip),
        .hit     (w_match),
        .ypix    (w_ypix)
    );

    // Y==0 marks an empty slot
    assign w_hb_rise   = HB & ~r_hb_last;
    assign w_hit       = w_match & (r_entry.y != 8'd0);
    assign w_last_addr = (obj_addr == LAST_ADDR);
    assign w_hits_inc  = r_hits + HCW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_entry   <= '0;
            r_hb_last <= 1'b0;
            r_hits    <= '0;
            obj_addr  <= 8'd0;
            dr_start  <= 1'b0;
            dr_x      <= 8'd0;
            dr_code   <= 7'd0;
            dr_ypix   <= '0;
            dr_hflip  <= 1'b0;
            dr_pal    <= 3'd0;
            dr_bank   <= 1'b0;
            scan_done <= 1'b1;
        end else if (cen) begin
            r_hb_last <= HB;
            dr_start  <= 1'b0;
            if (w_hb_rise && !VB) begin
                // A new HB restarts the walk even mid-scan; a pending hit is dropped
                r_state   <= ST_ADDR;
                obj_addr  <= 8'd0;
                r_hits    <= '0;
                scan_done <= 1'b0;
            end else if (VB && r_state != ST_IDLE) begin
                r_state   <= ST_IDLE;
                scan_done <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_ADDR: r_state <= ST_DATA;
                    ST_DATA: begin
                        r_entry <= obj_entry_t'(obj_data);
                        r_state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (w_hit) begin
                            r_state <= ST_WAIT;
                        end else if (w_last_addr) begin
                            r_state <= ST_DONE;
                        end else begin
                            obj_addr <= obj_addr + 8'd1;
                            r_state  <= ST_ADDR;
                        end
                    end
                    ST_WAIT: begin
                        if (!dr_busy) begin
                            dr_start <= 1'b1;
                            dr_x     <= r_entry.x;
                            dr_code  <= r_entry.code;
                            dr_ypix  <= w_ypix;
                            dr_hflip <= r_entry.hflip;
                            dr_pal   <= r_entry.pal;
                            dr_bank  <= r_entry.bank;
                            r_hits   <= w_hits_inc;
                            if (w_last_addr || w_hits_inc == HIT_LIMIT) begin
                                r_state <= ST_DONE;
                            end else begin
                                obj_addr <= obj_addr + 8'd1;
                                r_state  <= ST_ADDR;
                            end
                        end
                    end
                    ST_DONE: begin
                        scan_done <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_obj_scan.sv
// Directed bench for the object scanner with a one-cen-latency object RAM model.
module tb_jtpopeye_obj_scan;
    import jtpopeye_obj_scan_pkg::*;

    logic                  rst_n = 1'b0;
    logic                  clk   = 1'b0;
    logic                  cen   = 1'b0;
    logic                  VB    = 1'b0;
    logic                  HB    = 1'b0;
    logic [7:0]            vrender = 8'd0;
    logic [7:0]            obj_addr;
    logic [OBJ_DW-1:0]     obj_data;
    logic                  dr_start;
    logic                  dr_busy = 1'b0;
    logic [7:0]            dr_x;
    logic [6:0]            dr_code;
    logic [OBJ_YPIX_W-1:0] dr_ypix;
    logic                  dr_hflip;
    logic [2:0]            dr_pal;
    logic                  dr_bank;
    logic                  scan_done;

    logic [OBJ_DW-1:0]     mem [0:63];
    logic [OBJ_DW-1:0]     rd_q = '0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_dr    = 0;
    int n_b2b   = 0;
    logic prev_start = 1'b0;

    jtpopeye_obj_scan #(.OBJMAX(64), .HITMAX(8)) dut (
        .rst_n     (rst_n),
        .clk       (clk),
        .cen       (cen),
        .VB        (VB),
        .HB        (HB),
        .vrender   (vrender),
        .obj_addr  (obj_addr),
        .obj_data  (obj_data),
        .dr_start  (dr_start),
        .dr_busy   (dr_busy),
        .dr_x      (dr_x),
        .dr_code   (dr_code),
        .dr_ypix   (dr_ypix),
        .dr_hflip  (dr_hflip),
        .dr_pal    (dr_pal),
        .dr_bank   (dr_bank),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cen <= ~cen;

    always @(posedge clk) if (cen) rd_q <= mem[obj_addr];
    assign obj_data = rd_q;

    // Count draw pulses and flag any pulse lasting two cens
    always @(posedge clk) begin
        if (cen) begin
            if (dr_start) n_dr = n_dr + 1;
            if (dr_start && prev_start) n_b2b = n_b2b + 1;
            prev_start = dr_start;
        end
    end

    function automatic logic [OBJ_DW-1:0] mk(input logic [7:0] y, input logic [7:0] x,
        input logic [6:0] code, input logic hf, input logic [2:0] pal,
        input logic vf, input logic bk);
        return {bk, vf, pal, hf, code, y, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        do @(posedge clk); while (!cen);
        #1;
    endtask

    task automatic start_scan();
        HB = 1'b0;
        tick();
        HB = 1'b1;
        tick();
        HB = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cens);
        cens = 0;
        while (!scan_done && cens < budget) begin
            tick();
            cens++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic fill_all_hits();
        for (int i = 0; i < 64; i++) mem[i] = mk(8'h40, 8'(8'h80 + i), 7'h01, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int d0;
        int k;

        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", obj_addr, 0);
        chk("rst_start", dr_start, 0);
        chk("rst_done", scan_done, 1);
        chk("rst_x", dr_x, 0);
        chk("rst_code", dr_code, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();

        // Single hit at entry 0
        mem[0] = mk(8'h40, 8'h12, 7'h05, 1'b0, 3'd0, 1'b0, 1'b0);
        vrender = 8'h45;
        d0 = n_dr;
        start_scan();
        wait_done(400, c);
        chk("t1_cens", c, 194);
        chk("t1_ndr", n_dr - d0, 1);
        chk("t1_x", dr_x, 8'h12);
        chk("t1_code", dr_code, 7'h05);
        chk("t1_ypix", dr_ypix, 4'h5);
        chk("t1_addr", obj_addr, 63);
        chk("t1_done", scan_done, 1);

        // Vertical flip, then lines just below and above the object
        mem[0] = mk(8'h40, 8'h12, 7'h05, 1'b0, 3'd0, 1'b1, 1'b0);
        d0 = n_dr;
        start_scan();
        wait_done(400, c);
        chk("t2_ypix", dr_ypix, 4'hA);
        chk("t2_ndr", n_dr - d0, 1);
        vrender = 8'h50;
        d0 = n_dr;
        start_scan();
        wait_done(400, c);
        chk("t2_below_ndr", n_dr - d0, 0);
        chk("t2_below_cens", c, 193);
        vrender = 8'h3F;
        d0 = n_dr;
        start_scan();
        wait_done(400, c);
        chk("t2_above_ndr", n_dr - d0, 0);
        chk("t2_hold_ypix", dr_ypix, 4'hA);

        // Every entry hits: capped at 8 commands
        fill_all_hits();
        vrender = 8'h40;
        d0 = n_dr;
        start_scan();
        wait_done(400, c);
        chk("t3_ndr", n_dr - d0, 8);
        chk("t3_cens", c, 33);
        chk("t3_addr", obj_addr, 7);
        chk("t3_x", dr_x, 8'h87);
        chk("t3_ypix", dr_ypix, 0);

        // Drawer busy for 20 cens at the first hit
        clear_mem();
        mem[0] = mk(8'h40, 8'h9C, 7'h7F, 1'b1, 3'd5, 1'b0, 1'b1);
        vrender = 8'h4F;
        dr_busy = 1'b1;
        d0 = n_dr;
        start_scan();
        repeat (23) tick();
        chk("t4_wait_ndr", n_dr - d0, 0);
        chk("t4_wait_addr", obj_addr, 0);
        chk("t4_wait_start", dr_start, 0);
        dr_busy = 1'b0;
        tick();
        chk("t4_start", dr_start, 1);
        chk("t4_x", dr_x, 8'h9C);
        chk("t4_code", dr_code, 7'h7F);
        chk("t4_ypix", dr_ypix, 4'hF);
        chk("t4_hflip", dr_hflip, 1);
        chk("t4_pal", dr_pal, 3'd5);
        chk("t4_bank", dr_bank, 1);
        tick();
        chk("t4_pulse", dr_start, 0);
        wait_done(400, c);
        chk("t4_ndr", n_dr - d0, 1);
        chk("t4_addr", obj_addr, 63);

        // HB restart while a hit is pending at entry 30
        clear_mem();
        for (int i = 0; i < 7; i++) mem[i] = mk(8'h40, 8'(8'h20 + i), 7'h02, 1'b0, 3'd1, 1'b0, 1'b0);
        mem[30] = mk(8'h40, 8'h77, 7'h30, 1'b0, 3'd2, 1'b0, 1'b0);
        vrender = 8'h40;
        d0 = n_dr;
        start_scan();
        k = 0;
        while (obj_addr != 8'd30 && k < 300) begin
            tick();
            k++;
        end
        chk("t5_reach", obj_addr, 30);
        dr_busy = 1'b1;
        repeat (6) tick();
        chk("t5_pre_ndr", n_dr - d0, 7);
        chk("t5_pending", dr_start, 0);
        HB = 1'b0;
        tick();
        HB = 1'b1;
        tick();
        chk("t5_restart_addr", obj_addr, 0);
        chk("t5_restart_done", scan_done, 0);
        chk("t5_restart_start", dr_start, 0);
        HB = 1'b0;
        dr_busy = 1'b0;
        d0 = n_dr;
        wait_done(400, c);
        chk("t5_ndr", n_dr - d0, 8);
        chk("t5_addr", obj_addr, 30);
        chk("t5_x", dr_x, 8'h77);

        // HB rising during VB must not start a scan
        fill_all_hits();
        VB = 1'b1;
        d0 = n_dr;
        HB = 1'b0;
        tick();
        HB = 1'b1;
        tick();
        chk("t6_vb_done", scan_done, 1);
        repeat (10) tick();
        chk("t6_vb_done2", scan_done, 1);
        chk("t6_vb_addr", obj_addr, 30);
        VB = 1'b0;
        repeat (5) tick();
        chk("t6_vb_fall_done", scan_done, 1);
        chk("t6_vb_ndr", n_dr - d0, 0);
        HB = 1'b0;

        // VB rising mid-scan aborts
        d0 = n_dr;
        start_scan();
        tick();
        tick();
        chk("t6_mid_running", scan_done, 0);
        VB = 1'b1;
        tick();
        chk("t6_mid_done", scan_done, 1);
        repeat (40) tick();
        chk("t6_mid_ndr", n_dr - d0, 0);
        chk("t6_mid_start", dr_start, 0);
        VB = 1'b0;

        // Asynchronous reset in the middle of a scan
        d0 = n_dr;
        start_scan();
        k = 0;
        while (n_dr == d0 && k < 40) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("t7_pre_x", dr_x, 8'h80);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t7_addr", obj_addr, 0);
        chk("t7_x", dr_x, 0);
        chk("t7_done", scan_done, 1);
        chk("t7_start", dr_start, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        chk("no_back_to_back", n_b2b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
